// File: rtl/key_cmd_ctrl.sv
// key_cmd_ctrl: classifies debounced key activity into SINGLE/DOUBLE/LONG events and serves them
// round-robin on one valid/ready command port. Build option KEY_CMD_DBL_EN enables DOUBLE detection.
//
// state   | meaning
// IDLE    | key released, waiting for a press pulse
// PRESSED | key down, timer running toward LONG_CNT
// WAIT2   | released after a short press, waiting for a second press (KEY_CMD_DBL_EN only)
// HOLD    | event already reported for this press, waiting for release
module key_cmd_ctrl #(
  parameter int               N_KEYS   = 4,
  parameter int               CNT_W    = 26,
  parameter logic [CNT_W-1:0] LONG_CNT = CNT_W'(49_999_999),
  parameter logic [CNT_W-1:0] DBL_CNT  = CNT_W'(14_999_999),
  localparam int              IDX_W    = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_pulse_i,
  input  logic [N_KEYS-1:0] key_held_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [IDX_W-1:0]  cmd_key_o,
  output logic [1:0]        cmd_type_o,
  output logic [N_KEYS-1:0] ovf_sticky_o,
  input  logic              ovf_clr_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_WAIT2   = 2'd2,
    S_HOLD    = 2'd3
  } key_state_e;

  localparam logic [1:0] TYPE_NONE   = 2'b00;
  localparam logic [1:0] TYPE_SINGLE = 2'b01;
  localparam logic [1:0] TYPE_DOUBLE = 2'b10;
  localparam logic [1:0] TYPE_LONG   = 2'b11;

  localparam logic [CNT_W-1:0] LONG_TC = LONG_CNT - CNT_W'(1);
  localparam logic [CNT_W-1:0] TMR_MAX = '1;

  key_state_e       state_q     [N_KEYS];
  key_state_e       state_d     [N_KEYS];
  logic [CNT_W-1:0] timer_q     [N_KEYS];
  logic [CNT_W-1:0] timer_d     [N_KEYS];
  logic [CNT_W-1:0] timer_inc   [N_KEYS];
  logic [1:0]       emit_type_q [N_KEYS];
  logic [1:0]       emit_type_d [N_KEYS];
  logic [1:0]       ptype_q     [N_KEYS];
  logic [1:0]       ptype_d     [N_KEYS];
  logic [N_KEYS-1:0] emit_q, emit_d;
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] ovf_q, ovf_d;
  logic [N_KEYS-1:0] grant;

  logic             cmd_valid_q, cmd_valid_d;
  logic [IDX_W-1:0] cmd_key_q, cmd_key_d;
  logic [1:0]       cmd_type_q, cmd_type_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             load;
  logic             found;
  logic [IDX_W-1:0] pick;

`ifdef KEY_CMD_DBL_EN
  localparam logic [CNT_W-1:0] DBL_TC = DBL_CNT - CNT_W'(1);
`else
  logic dbl_cnt_unused;
  assign dbl_cnt_unused = ^DBL_CNT;
`endif

  // Per-key gesture FSMs; the emit flag is registered so an event reaches pending one edge later.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i]     = state_q[i];
      timer_inc[i]   = (timer_q[i] == TMR_MAX) ? timer_q[i] : timer_q[i] + CNT_W'(1);
      timer_d[i]     = timer_q[i];
      emit_d[i]      = 1'b0;
      emit_type_d[i] = TYPE_NONE;
      case (state_q[i])
        S_IDLE: begin
          if (key_pulse_i[i]) begin
            state_d[i] = S_PRESSED;
            timer_d[i] = '0;
          end
        end
        S_PRESSED: begin
          timer_d[i] = timer_inc[i];
          if (key_held_i[i] && (timer_q[i] == LONG_TC)) begin
            state_d[i]     = S_HOLD;
            timer_d[i]     = '0;
            emit_d[i]      = 1'b1;
            emit_type_d[i] = TYPE_LONG;
          end else if (!key_held_i[i]) begin
            timer_d[i] = '0;
`ifdef KEY_CMD_DBL_EN
            state_d[i] = S_WAIT2;
`else
            state_d[i]     = S_IDLE;
            emit_d[i]      = 1'b1;
            emit_type_d[i] = TYPE_SINGLE;
`endif
          end
        end
`ifdef KEY_CMD_DBL_EN
        S_WAIT2: begin
          timer_d[i] = timer_inc[i];
          if (key_pulse_i[i]) begin
            state_d[i]     = S_HOLD;
            timer_d[i]     = '0;
            emit_d[i]      = 1'b1;
            emit_type_d[i] = TYPE_DOUBLE;
          end else if (timer_q[i] == DBL_TC) begin
            state_d[i]     = S_IDLE;
            timer_d[i]     = '0;
            emit_d[i]      = 1'b1;
            emit_type_d[i] = TYPE_SINGLE;
          end
        end
`endif
        S_HOLD: begin
          if (!key_held_i[i]) begin
            state_d[i] = S_IDLE;
            timer_d[i] = '0;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  // Round-robin pick starting one past the last granted key.
  always_comb begin
    int j;
    j     = 0;
    load  = !cmd_valid_q || cmd_ready_i;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_KEYS; k++) begin
      j = int'(last_grant_q) + k;
      if (j >= N_KEYS) j = j - N_KEYS;
      if (!found && pending_q[j]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
    for (int i = 0; i < N_KEYS; i++) begin
      grant[i] = load && found && (pick == IDX_W'(i));
    end
  end

  // A new event is dropped (and flagged) only when the slot is still occupied after this cycle's grant.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      pending_d[i] = pending_q[i] & ~grant[i];
      ptype_d[i]   = ptype_q[i];
      ovf_d[i]     = ovf_q[i] & ~ovf_clr_i;
      if (emit_q[i]) begin
        if (pending_q[i] && !grant[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          ptype_d[i]   = emit_type_q[i];
        end
      end
    end
  end

  always_comb begin
    cmd_valid_d  = cmd_valid_q;
    cmd_key_d    = cmd_key_q;
    cmd_type_d   = cmd_type_q;
    last_grant_d = last_grant_q;
    if (load) begin
      cmd_valid_d = found;
      if (found) begin
        cmd_key_d    = pick;
        cmd_type_d   = ptype_q[pick];
        last_grant_d = pick;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i]     <= S_IDLE;
        timer_q[i]     <= '0;
        emit_type_q[i] <= TYPE_NONE;
        ptype_q[i]     <= TYPE_NONE;
      end
      emit_q       <= '0;
      pending_q    <= '0;
      ovf_q        <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_key_q    <= '0;
      cmd_type_q   <= TYPE_NONE;
      last_grant_q <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i]     <= state_d[i];
        timer_q[i]     <= timer_d[i];
        emit_type_q[i] <= emit_type_d[i];
        ptype_q[i]     <= ptype_d[i];
      end
      emit_q       <= emit_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_key_q    <= cmd_key_d;
      cmd_type_q   <= cmd_type_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_key_o    = cmd_key_q;
  assign cmd_type_o   = cmd_type_q;
  assign ovf_sticky_o = ovf_q;

endmodule
